// File: rtl/sub_div_ctrl_pkg.sv
// Shared definitions for the sub_div_ctrl divider slice.
//   DIV_W      operand/result width (fixed at 32 while the shared subtractor is used)
//   DIV_MSB    index of the operand MSB
//   DIV_MSB2   index just below the MSB, used for the one-bit shifts
//   CNT_W      iteration counter width, clog2(DIV_W)+1
//   state_t    sequencer states S_IDLE / S_RUN / S_DONE
//   CNT_LAST   counter value of the final iteration
//   CNT_ONE    counter increment
package sub_div_ctrl_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_MSB  = DIV_W - 1;
    localparam int DIV_MSB2 = DIV_W - 2;
    localparam int CNT_W    = $clog2(DIV_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MSB);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

endpackage

// File: rtl/sub_div_ctrl_sub.sv
// Shared subtractor used by the divider.
//   a_i    minuend (DIV_W bits)
//   b_i    subtrahend (DIV_W bits)
//   out_o  a_i + ~b_i + 1, i.e. a_i - b_i modulo 2^DIV_W
//   co_o   carry out; 1 when a_i >= b_i (unsigned), meaning no borrow
module sub_div_ctrl_sub
    import sub_div_ctrl_pkg::*;
(
    input  logic [DIV_MSB:0] a_i,
    input  logic [DIV_MSB:0] b_i,
    output logic [DIV_MSB:0] out_o,
    output logic             co_o
);

    // One extra bit captures the carry of the two's-complement add.
    logic [DIV_W:0] sum;

    assign sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{DIV_W{1'b0}}, 1'b1};
    assign out_o = sum[DIV_MSB:0];
    assign co_o  = sum[DIV_W];

endmodule

// File: rtl/sub_div_ctrl.sv
// Multi-cycle unsigned restoring divider sequencer, one quotient bit per
// clock, built around a single shared subtractor.
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while in RUN or DONE
//   done         one-cycle pulse; results valid from this cycle
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  set with done when the captured divisor was zero
module sub_div_ctrl
    import sub_div_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_MSB:0] dividend,
    input  logic [DIV_MSB:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_MSB:0] quotient,
    output logic [DIV_MSB:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [DIV_MSB:0] q_q;      // dividend shifting out / quotient shifting in
    logic [DIV_MSB:0] r_q;      // partial remainder
    logic [DIV_MSB:0] d_q;      // captured divisor
    logic [CNT_W-1:0] cnt_q;
    logic [DIV_MSB:0] quot_q;
    logic [DIV_MSB:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic             divisor_zero;
    logic             last_iter;
    logic [DIV_MSB:0] s_low;
    logic [DIV_MSB:0] diff;
    logic             co;
    logic             ge;
    logic [DIV_MSB:0] r_next;
    logic [DIV_MSB:0] q_next;

    assign divisor_zero = (divisor == '0);
    assign last_iter    = (cnt_q == CNT_LAST);

    // Low DIV_W bits of the shifted partial remainder {r_q, q_q[MSB]};
    // the dropped top bit is r_q[MSB].
    assign s_low = {r_q[DIV_MSB2:0], q_q[DIV_MSB]};

    sub_div_ctrl_sub u_sub (
        .a_i   (s_low),
        .b_i   (d_q),
        .out_o (diff),
        .co_o  (co)
    );

    // When the dropped top bit is set the shifted value exceeds any divisor,
    // so subtraction must happen; the low bits of diff are still exact.
    assign ge     = r_q[DIV_MSB] | co;
    assign r_next = ge ? diff : s_low;
    assign q_next = {q_q[DIV_MSB2:0], ge};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = divisor_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Status outputs are registered from the next state so they
            // line up with the state they describe.
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= divisor;
                        r_q   <= '0;
                        cnt_q <= '0;
                        dbz_q <= divisor_zero;
                        if (divisor_zero) begin
                            quot_q <= '1;
                            rem_q  <= dividend;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= r_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (last_iter) begin
                        quot_q <= q_next;
                        rem_q  <= r_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sub_div_ctrl.sv
module tb_sub_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    sub_div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted op occupies a fixed number of cycles
    // (1 for divide-by-zero, WIDTH+1 otherwise); results come from plain
    // arithmetic and are published in the done cycle.
    bit          m_active = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    bit          m_dbz = 1'b0, p_dbz = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_lat = 0;
            m_q = '0; m_r = '0; m_dbz = 1'b0;
            p_q = '0; p_r = '0; p_dbz = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_age = 1;
                m_dbz = 1'b0;
                if (divisor == 0) begin
                    m_lat = 1; p_q = 32'hFFFF_FFFF; p_r = dividend; p_dbz = 1'b1;
                end else begin
                    m_lat = 33; p_q = dividend / divisor; p_r = dividend % divisor; p_dbz = 1'b0;
                end
                if (m_age == m_lat) begin
                    m_q = p_q; m_r = p_r; m_dbz = p_dbz;
                end
            end
        end else begin
            m_age++;
            if (m_age > m_lat) begin
                m_active = 1'b0;
            end else if (m_age == m_lat) begin
                m_q = p_q; m_r = p_r; m_dbz = p_dbz;
            end
        end
    end

    // Compare process: checks every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("done", {31'd0, done}, {31'd0, (m_active && m_age == m_lat)});
            chk("dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
            if (!m_active || m_age == m_lat) begin
                chk("quot", quotient, m_q);
                chk("rem", remainder, m_r);
            end
        end
    end

    // Issue one op (DUT must be idle), wait for done, check literals.
    // inj_cyc > 0 pulses a 50/5 start in that cycle; noise drives random
    // start pulses and operands while busy.
    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int elat, input int inj_cyc, input bit noise);
        int k;
        bit seen;
        @(posedge clk); #1;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; k = 1; seen = 1'b0;
        dividend = $urandom; divisor = $urandom;
        while (k < 100) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == inj_cyc) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end else if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                dividend = $urandom; divisor = $urandom_range(0, 3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_lat"}, k, elat);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", nm, a, b,
                 quotient, remainder, div_by_zero, k);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int seen_done;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        $display("reset: busy=%0d done=%0d q=%0d r=%0d dbz=%0d", busy, done, quotient, remainder, div_by_zero);
        rst = 1'b0;

        do_op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0, 1'b0);
        do_op("dmax_80000001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 0, 1'b0);
        do_op("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33, 0, 1'b0);
        do_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0, 1'b0);
        do_op("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0, 1'b0);
        do_op("d100_7_inj", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10, 1'b0);

        // Reset in the middle of a run: no done, outputs back to zero.
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", seen_done, 32'd0);
        $display("op mid_reset: done pulses after reset=%0d", seen_done);
        do_op("d81_9", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33, 0, 1'b0);

        // start held high continuously with changing operands.
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            dividend = $urandom;
            divisor = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 1000);
            @(posedge clk); #1;
            if (done) $display("op held: q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
        end
        start = 1'b0;
        wait_idle();

        // Randomized ops with random start noise while busy.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = a;
                2:       b = $urandom | 32'h8000_0000;
                3, 4:    b = $urandom_range(1, 255);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 0)
                do_op("rand", a, b, 32'hFFFF_FFFF, a, 1'b1, 1, 0, 1'b1);
            else
                do_op("rand", a, b, a / b, a % b, 1'b0, 33, 0, 1'b1);
        end
        wait_idle();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
